// File: rtl/rv32_mem.sv
// rv32_mem: RV32 memory stage between execute and writeback.
//   Issues load/store on a ready-handshake data bus, aligns/extends load data,
//   resolves branches (combinational mispredict), registers results for writeback.
//   Latency: 1 cycle with zero-wait bus; +N cycles for N bus wait states.
//   Backpressure: stall_out while a bus access waits or a result sits in the hold buffer;
//   stall_in freezes the output registers (a completed load parks in the hold buffer).
// Ports: execute-side control/data (*_in), data bus (data_*), hazard (stall_*),
//   fetch redirect (branch_*_out), writeback (valid_out, rd_*, misaligned_out).
module rv32_mem (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_in,
  input  logic        branch_predicted_taken_in,
  input  logic        valid_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [1:0]  mem_width_in,
  input  logic        mem_zero_extend_in,
  input  logic        mem_fence_in,
  input  logic [1:0]  branch_op_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_write_in,
  input  logic [31:0] result_in,
  input  logic [31:0] rs2_value_in,
  input  logic [31:0] branch_pc_in,
  output logic [31:0] data_address_out,
  output logic        data_read_out,
  output logic        data_write_out,
  output logic [3:0]  data_write_mask_out,
  output logic [31:0] data_write_value_out,
  input  logic [31:0] data_read_value_in,
  input  logic        data_ready_in,
  output logic        stall_out,
  output logic        branch_mispredicted_out,
  output logic [31:0] branch_pc_out,
  output logic        valid_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_out,
  output logic [31:0] rd_value_out,
  output logic        misaligned_out
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t      state, state_next;
  logic [31:0] hold_value;
  logic        aligned, mem_op, access, misaligned, bus_en, taken;
  logic        out_load, from_hold, capture;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_value, rd_value;

  always_comb begin
    case (mem_width_in)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~result_in[0];
      default: aligned = (result_in[1:0] == 2'b00);
    endcase
  end

  // Fences travel through as non-memory instructions.
  assign mem_op     = valid_in & (mem_read_in | mem_write_in) & ~mem_fence_in;
  assign access     = mem_op & aligned;
  assign misaligned = mem_op & ~aligned;

  // Requests drop as soon as reset is asserted so the agent abandons the access.
  assign bus_en           = reset_n & (state != HOLD) & access;
  assign data_read_out    = bus_en & mem_read_in;
  assign data_write_out   = bus_en & mem_write_in;
  assign data_address_out = {result_in[31:2], 2'b00};

  always_comb begin
    data_write_mask_out  = 4'b1111;
    data_write_value_out = rs2_value_in;
    case (mem_width_in)
      2'b00: begin
        data_write_mask_out  = 4'b0001 << result_in[1:0];
        data_write_value_out = {4{rs2_value_in[7:0]}};
      end
      2'b01: begin
        data_write_mask_out  = result_in[1] ? 4'b1100 : 4'b0011;
        data_write_value_out = {2{rs2_value_in[15:0]}};
      end
      default: ;
    endcase
    if (!data_write_out) data_write_mask_out = 4'b0000;
  end

  always_comb begin
    case (result_in[1:0])
      2'd0:    load_byte = data_read_value_in[7:0];
      2'd1:    load_byte = data_read_value_in[15:8];
      2'd2:    load_byte = data_read_value_in[23:16];
      default: load_byte = data_read_value_in[31:24];
    endcase
    load_half = result_in[1] ? data_read_value_in[31:16] : data_read_value_in[15:0];
    case (mem_width_in)
      2'b00:   load_value = {{24{load_byte[7]  & ~mem_zero_extend_in}}, load_byte};
      2'b01:   load_value = {{16{load_half[15] & ~mem_zero_extend_in}}, load_half};
      default: load_value = data_read_value_in;
    endcase
  end

  assign rd_value = (mem_read_in & ~mem_fence_in) ? load_value : result_in;

  always_comb begin
    case (branch_op_in)
      2'd0:    taken = 1'b0;
      2'd1:    taken = (result_in == 32'd0);
      2'd2:    taken = (result_in != 32'd0);
      default: taken = 1'b1;
    endcase
  end

  // The instruction in this stage is only a fresh one while IDLE.
  assign branch_mispredicted_out = (state == IDLE) & valid_in & (taken != branch_predicted_taken_in);
  assign branch_pc_out = ((state == IDLE) && taken) ? branch_pc_in : 32'd0;

  assign stall_out = (access & ~data_ready_in) | (state == HOLD);

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    out_load   = 1'b0;
    from_hold  = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (data_ready_in) begin
            if (stall_in) begin
              state_next = HOLD;
              capture    = 1'b1;
            end else begin
              out_load = 1'b1;
            end
          end else begin
            state_next = WAIT;
          end
        end else begin
          out_load = ~stall_in;
        end
      end
      WAIT: begin
        if (data_ready_in) begin
          if (stall_in) begin
            state_next = HOLD;
            capture    = 1'b1;
          end else begin
            state_next = IDLE;
            out_load   = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!stall_in) begin
          state_next = IDLE;
          out_load   = 1'b1;
          from_hold  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      hold_value     <= 32'd0;
      valid_out      <= 1'b0;
      rd_out         <= 5'd0;
      rd_write_out   <= 1'b0;
      rd_value_out   <= 32'd0;
      misaligned_out <= 1'b0;
    end else begin
      state <= state_next;
      if (capture) hold_value <= rd_value;
      if (out_load) begin
        valid_out      <= valid_in;
        rd_out         <= rd_in;
        rd_write_out   <= rd_write_in & ~mem_write_in & ~misaligned;
        rd_value_out   <= from_hold ? hold_value : rd_value;
        misaligned_out <= misaligned;
      end
    end
  end

endmodule

// File: tb/tb_rv32_mem.sv
// tb_rv32_mem: directed bench for rv32_mem.
//   Expected writeback results are queued when an instruction is driven and
//   compared when the DUT registers it; combinational bus/branch outputs checked in place.
module tb_rv32_mem;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_in, branch_predicted_taken_in, valid_in, mem_read_in, mem_write_in;
  logic [1:0]  mem_width_in, branch_op_in;
  logic        mem_zero_extend_in, mem_fence_in, rd_write_in, data_ready_in;
  logic [4:0]  rd_in;
  logic [31:0] result_in, rs2_value_in, branch_pc_in, data_read_value_in;
  logic [31:0] data_address_out, data_write_value_out, branch_pc_out, rd_value_out;
  logic        data_read_out, data_write_out, stall_out, branch_mispredicted_out;
  logic        valid_out, rd_write_out, misaligned_out;
  logic [3:0]  data_write_mask_out;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] value;
    logic        chk_value;
    logic [4:0]  rd;
    logic        rd_write;
    logic        mis;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  rv32_mem dut (
    .clk(clk), .reset_n(reset_n), .stall_in(stall_in),
    .branch_predicted_taken_in(branch_predicted_taken_in),
    .valid_in(valid_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_width_in(mem_width_in), .mem_zero_extend_in(mem_zero_extend_in),
    .mem_fence_in(mem_fence_in), .branch_op_in(branch_op_in), .rd_in(rd_in),
    .rd_write_in(rd_write_in), .result_in(result_in), .rs2_value_in(rs2_value_in),
    .branch_pc_in(branch_pc_in), .data_address_out(data_address_out),
    .data_read_out(data_read_out), .data_write_out(data_write_out),
    .data_write_mask_out(data_write_mask_out), .data_write_value_out(data_write_value_out),
    .data_read_value_in(data_read_value_in), .data_ready_in(data_ready_in),
    .stall_out(stall_out), .branch_mispredicted_out(branch_mispredicted_out),
    .branch_pc_out(branch_pc_out), .valid_out(valid_out), .rd_out(rd_out),
    .rd_write_out(rd_write_out), .rd_value_out(rd_value_out), .misaligned_out(misaligned_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] v, input logic cv, input logic [4:0] r,
                      input logic rw, input logic m);
    exp_t e;
    e.value = v; e.chk_value = cv; e.rd = r; e.rd_write = rw; e.mis = m;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".valid"}, valid_out, 1'b1);
      check({tag, ".rd"}, rd_out, e.rd);
      check({tag, ".rd_write"}, rd_write_out, e.rd_write);
      check({tag, ".misaligned"}, misaligned_out, e.mis);
      if (e.chk_value) check({tag, ".value"}, rd_value_out, e.value);
    end
  endtask

  task automatic clear_inputs();
    stall_in = 0; branch_predicted_taken_in = 0; valid_in = 0; mem_read_in = 0;
    mem_write_in = 0; mem_width_in = 2'b10; mem_zero_extend_in = 0; mem_fence_in = 0;
    branch_op_in = 0; rd_in = 0; rd_write_in = 0; result_in = 0; rs2_value_in = 0;
    branch_pc_in = 0; data_read_value_in = 0; data_ready_in = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset_n = 0;
    clear_inputs();
    repeat (2) cycle();
    check("rst.valid", valid_out, 1'b0);
    check("rst.rd_write", rd_write_out, 1'b0);
    check("rst.rd", rd_out, 5'd0);
    check("rst.value", rd_value_out, 32'd0);
    check("rst.misaligned", misaligned_out, 1'b0);
    check("rst.read", data_read_out, 1'b0);
    reset_n = 1;

    // LB 0x103, zero-wait
    valid_in = 1; mem_read_in = 1; mem_width_in = 2'b00; rd_in = 5; rd_write_in = 1;
    result_in = 32'h103; data_ready_in = 1; data_read_value_in = 32'h80FF_0000;
    #1;
    check("lb.req", data_read_out, 1'b1);
    check("lb.addr", data_address_out, 32'h100);
    check("lb.stall", stall_out, 1'b0);
    push(32'hFFFF_FF80, 1, 5, 1, 0);
    cycle();
    pop_check("lb");

    // LBU same
    mem_zero_extend_in = 1;
    push(32'h0000_0080, 1, 5, 1, 0);
    cycle();
    pop_check("lbu");

    // SH 0x202
    clear_inputs();
    valid_in = 1; mem_write_in = 1; mem_width_in = 2'b01; rd_in = 3; rd_write_in = 1;
    result_in = 32'h202; rs2_value_in = 32'h1234_ABCD; data_ready_in = 1;
    #1;
    check("sh.mask", data_write_mask_out, 4'b1100);
    check("sh.wdata", data_write_value_out, 32'hABCD_ABCD);
    check("sh.addr", data_address_out, 32'h200);
    check("sh.wreq", data_write_out, 1'b1);
    check("sh.rreq", data_read_out, 1'b0);
    push(32'h202, 1, 3, 0, 0);
    cycle();
    pop_check("sh");

    // LW 0x40 with 3 wait states
    clear_inputs();
    valid_in = 1; mem_read_in = 1; mem_width_in = 2'b10; rd_in = 6; rd_write_in = 1;
    result_in = 32'h40; data_ready_in = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lw_wait.stall", stall_out, 1'b1);
      check("lw_wait.req", data_read_out, 1'b1);
      check("lw_wait.addr", data_address_out, 32'h40);
      cycle();
      check("lw_wait.frozen", rd_value_out, 32'h202);
    end
    data_ready_in = 1; data_read_value_in = 32'hDEAD_BEEF;
    #1;
    check("lw_done.stall", stall_out, 1'b0);
    push(32'hDEAD_BEEF, 1, 6, 1, 0);
    cycle();
    pop_check("lw_wait");

    // LW completing under stall_in -> HOLD
    result_in = 32'h44; rd_in = 7; data_read_value_in = 32'h1357_2468; stall_in = 1;
    #1;
    check("hold.entry_stall", stall_out, 1'b0);
    check("hold.entry_req", data_read_out, 1'b1);
    cycle();
    check("hold.req1", data_read_out, 1'b0);
    check("hold.stall1", stall_out, 1'b1);
    check("hold.frozen1", rd_value_out, 32'hDEAD_BEEF);
    data_read_value_in = 32'hFFFF_FFFF; data_ready_in = 0;
    cycle();
    check("hold.stall2", stall_out, 1'b1);
    check("hold.frozen2", rd_value_out, 32'hDEAD_BEEF);
    stall_in = 0;
    #1;
    check("hold.req3", data_read_out, 1'b0);
    push(32'h1357_2468, 1, 7, 1, 0);
    cycle();
    pop_check("hold");

    // Branches
    clear_inputs();
    valid_in = 1; branch_op_in = 2'd1; result_in = 0; branch_pc_in = 32'h8000_0010;
    #1;
    check("br.mispred", branch_mispredicted_out, 1'b1);
    check("br.pc", branch_pc_out, 32'h8000_0010);
    branch_predicted_taken_in = 1;
    #1;
    check("br.pred_ok", branch_mispredicted_out, 1'b0);
    branch_op_in = 2'd2;
    #1;
    check("br.nt_mispred", branch_mispredicted_out, 1'b1);
    check("br.nt_pc", branch_pc_out, 32'd0);
    rd_in = 2; rd_write_in = 1; result_in = 32'h55;
    push(32'h55, 1, 2, 1, 0);
    cycle();
    pop_check("alu");

    // Fence: no bus activity
    clear_inputs();
    valid_in = 1; mem_read_in = 1; mem_fence_in = 1; result_in = 32'h40;
    #1;
    check("fence.req", data_read_out, 1'b0);
    check("fence.stall", stall_out, 1'b0);
    cycle();

    // LH misaligned
    clear_inputs();
    valid_in = 1; mem_read_in = 1; mem_width_in = 2'b01; rd_in = 9; rd_write_in = 1;
    result_in = 32'h101; data_ready_in = 1;
    #1;
    check("mis.req", data_read_out, 1'b0);
    check("mis.stall", stall_out, 1'b0);
    push(32'd0, 0, 9, 0, 1);
    cycle();
    pop_check("mis");

    // Reset mid-WAIT
    clear_inputs();
    valid_in = 1; mem_read_in = 1; mem_width_in = 2'b10; rd_in = 4; rd_write_in = 1;
    result_in = 32'h80; data_ready_in = 0;
    cycle();
    check("rstw.stall", stall_out, 1'b1);
    reset_n = 0;
    #1;
    check("rstw.req_drop", data_read_out, 1'b0);
    cycle();
    check("rstw.valid", valid_out, 1'b0);
    check("rstw.rd_write", rd_write_out, 1'b0);
    check("rstw.value", rd_value_out, 32'd0);
    check("rstw.misaligned", misaligned_out, 1'b0);
    reset_n = 1;
    clear_inputs();
    valid_in = 1; branch_op_in = 2'd3;
    #1;
    check("rstw.idle_mispred", branch_mispredicted_out, 1'b1);
    check("rstw.idle_stall", stall_out, 1'b0);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
